// File: rtl/core_mem_bridge.sv
// Core-to-memory bridge: arbitrates instruction-fetch and data ports onto one memory port
// and returns in-order responses after a fixed read latency.
module core_mem_bridge #(
  parameter int unsigned LOAD_LATENCY  = 1,
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned ACTUAL_ADDR_W = 13,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned WE_W          = 8,
  parameter int unsigned STARVE_LIMIT  = 4,
  parameter int unsigned FAULT_CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     if_req_valid,
  output logic                     if_req_ready,
  input  logic [ADDR_W-1:0]        if_addr,
  output logic                     if_rsp_valid,
  output logic [DATA_W-1:0]        if_rsp_data,
  output logic                     if_rsp_err,

  input  logic                     d_req_valid,
  output logic                     d_req_ready,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [WE_W-1:0]          d_we,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_rsp_valid,
  output logic [DATA_W-1:0]        d_rsp_data,
  output logic                     d_rsp_err,

  output logic                     mem_en,
  output logic [ACTUAL_ADDR_W-1:0] mem_addr,
  output logic [WE_W-1:0]          mem_we,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,

  output logic [FAULT_CNT_W-1:0]   fault_cnt
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic valid;
    logic port;   // 1 = data port, 0 = fetch port
    logic store;
    logic err;
  } rsp_t;

  rsp_t                   pipe_q [LOAD_LATENCY];
  rsp_t                   issue_rsp;
  rsp_t                   head;
  logic [StarveW-1:0]     starve_q, starve_d;
  logic [FAULT_CNT_W-1:0] fault_q, fault_d;
  logic                   force_if;
  logic                   d_issue, if_issue, any_issue;
  logic                   d_in_range, if_in_range, issue_fault;
  logic                   d_is_store;

  assign d_in_range  = (d_addr[ADDR_W-1:ACTUAL_ADDR_W] == '0);
  assign if_in_range = (if_addr[ADDR_W-1:ACTUAL_ADDR_W] == '0);
  assign d_is_store  = |d_we;
  assign head        = pipe_q[LOAD_LATENCY-1];

  // Arbitration and issue; the data port wins unless fetch has starved long enough.
  always_comb begin
    force_if     = if_req_valid && (starve_q >= StarveW'(STARVE_LIMIT));
    if_req_ready = !rst && (!d_req_valid || force_if);
    d_req_ready  = !rst && !force_if;
    d_issue      = d_req_valid && d_req_ready;
    if_issue     = if_req_valid && if_req_ready && !d_issue;
    any_issue    = d_issue || if_issue;
    issue_fault  = d_issue ? !d_in_range : (if_issue && !if_in_range);

    issue_rsp       = '0;
    issue_rsp.valid = any_issue;
    issue_rsp.port  = d_issue;
    issue_rsp.store = d_issue && d_is_store;
    issue_rsp.err   = issue_fault;

    mem_en    = any_issue && !issue_fault;
    mem_addr  = d_issue ? d_addr[ACTUAL_ADDR_W-1:0] : if_addr[ACTUAL_ADDR_W-1:0];
    mem_we    = (d_issue && d_in_range) ? d_we : '0;
    mem_wdata = d_wdata;
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req_valid || if_issue) begin
      starve_d = '0;
    end else if (d_issue && (starve_q != '1)) begin
      starve_d = starve_q + 1'b1;
    end

    fault_d = fault_q;
    if (issue_fault && (fault_q != '1)) begin
      fault_d = fault_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      fault_q  <= '0;
      for (int unsigned i = 0; i < LOAD_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      starve_q  <= starve_d;
      fault_q   <= fault_d;
      pipe_q[0] <= issue_rsp;
      for (int unsigned i = 1; i < LOAD_LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  // Outputs are masked during rst so stale state never leaks in the first reset cycle.
  always_comb begin
    if_rsp_valid = !rst && head.valid && !head.port;
    d_rsp_valid  = !rst && head.valid && head.port;
    if_rsp_err   = if_rsp_valid && head.err;
    d_rsp_err    = d_rsp_valid && head.err;
    if_rsp_data  = (if_rsp_valid && !head.err) ? mem_rdata : '0;
    d_rsp_data   = (d_rsp_valid && !head.err && !head.store) ? mem_rdata : '0;
    fault_cnt    = rst ? '0 : fault_q;
  end

endmodule

// File: tb/tb_core_mem_bridge.sv
// Directed self-checking bench for core_mem_bridge; three instances cover latency 2, latency 3
// and a narrow saturating fault counter.
module tb_core_mem_bridge;

  logic        clk;
  logic        rst;
  logic        if_req_valid;
  logic [31:0] if_addr;
  logic        d_req_valid;
  logic [31:0] d_addr;
  logic [7:0]  d_we;
  logic [63:0] d_wdata;
  logic [63:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Instance a: LOAD_LATENCY=2
  logic        a_if_req_ready, a_if_rsp_valid, a_if_rsp_err;
  logic [63:0] a_if_rsp_data;
  logic        a_d_req_ready, a_d_rsp_valid, a_d_rsp_err;
  logic [63:0] a_d_rsp_data;
  logic        a_mem_en;
  logic [12:0] a_mem_addr;
  logic [7:0]  a_mem_we;
  logic [63:0] a_mem_wdata;
  logic [15:0] a_fault_cnt;

  // Instance b: LOAD_LATENCY=3
  logic        b_if_req_ready, b_if_rsp_valid, b_if_rsp_err;
  logic [63:0] b_if_rsp_data;
  logic        b_d_req_ready, b_d_rsp_valid, b_d_rsp_err;
  logic [63:0] b_d_rsp_data;
  logic        b_mem_en;
  logic [12:0] b_mem_addr;
  logic [7:0]  b_mem_we;
  logic [63:0] b_mem_wdata;
  logic [15:0] b_fault_cnt;

  // Instance c: LOAD_LATENCY=1, FAULT_CNT_W=2
  logic        c_if_req_ready, c_if_rsp_valid, c_if_rsp_err;
  logic [63:0] c_if_rsp_data;
  logic        c_d_req_ready, c_d_rsp_valid, c_d_rsp_err;
  logic [63:0] c_d_rsp_data;
  logic        c_mem_en;
  logic [12:0] c_mem_addr;
  logic [7:0]  c_mem_we;
  logic [63:0] c_mem_wdata;
  logic [1:0]  c_fault_cnt;

  core_mem_bridge #(.LOAD_LATENCY(2)) dut_a (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(a_if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(a_if_rsp_valid), .if_rsp_data(a_if_rsp_data), .if_rsp_err(a_if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(a_d_req_ready), .d_addr(d_addr), .d_we(d_we),
    .d_wdata(d_wdata), .d_rsp_valid(a_d_rsp_valid), .d_rsp_data(a_d_rsp_data),
    .d_rsp_err(a_d_rsp_err), .mem_en(a_mem_en), .mem_addr(a_mem_addr), .mem_we(a_mem_we),
    .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata), .fault_cnt(a_fault_cnt)
  );

  core_mem_bridge #(.LOAD_LATENCY(3)) dut_b (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(b_if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(b_if_rsp_valid), .if_rsp_data(b_if_rsp_data), .if_rsp_err(b_if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(b_d_req_ready), .d_addr(d_addr), .d_we(d_we),
    .d_wdata(d_wdata), .d_rsp_valid(b_d_rsp_valid), .d_rsp_data(b_d_rsp_data),
    .d_rsp_err(b_d_rsp_err), .mem_en(b_mem_en), .mem_addr(b_mem_addr), .mem_we(b_mem_we),
    .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata), .fault_cnt(b_fault_cnt)
  );

  core_mem_bridge #(.LOAD_LATENCY(1), .FAULT_CNT_W(2)) dut_c (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_req_ready(c_if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(c_if_rsp_valid), .if_rsp_data(c_if_rsp_data), .if_rsp_err(c_if_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(c_d_req_ready), .d_addr(d_addr), .d_we(d_we),
    .d_wdata(d_wdata), .d_rsp_valid(c_d_rsp_valid), .d_rsp_data(c_d_rsp_data),
    .d_rsp_err(c_d_rsp_err), .mem_en(c_mem_en), .mem_addr(c_mem_addr), .mem_we(c_mem_we),
    .mem_wdata(c_mem_wdata), .mem_rdata(mem_rdata), .fault_cnt(c_fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    if_req_valid = 1'b0;
    if_addr      = '0;
    d_req_valid  = 1'b0;
    d_addr       = '0;
    d_we         = '0;
    d_wdata      = '0;
    mem_rdata    = '0;
  endtask

  // Holds rst for two cycles, then deasserts it at a negedge; the caller's first drive lands
  // in the first cycle with rst=0.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst          = 1'b1;
    if_req_valid = 1'b1;
    d_req_valid  = 1'b1;
    d_addr       = 32'h10;
    d_we         = 8'hFF;
    #1;
    checks++;
    if (a_if_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_if_ready got %0b want 0", a_if_req_ready);
    end
    checks++;
    if (a_d_req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_d_ready got %0b want 0", a_d_req_ready);
    end
    checks++;
    if (a_mem_en !== 1'b0 || a_mem_we !== 8'h00) begin
      errors++; $display("FAIL reset_mem got en=%0b we=%0h want en=0 we=0", a_mem_en, a_mem_we);
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_d_rsp_valid !== 1'b0 || a_if_rsp_valid !== 1'b0 || a_d_rsp_err !== 1'b0 ||
        a_d_rsp_data !== 64'h0 || a_fault_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_rsp got dv=%0b iv=%0b err=%0b data=%0h fc=%0h want all 0",
               a_d_rsp_valid, a_if_rsp_valid, a_d_rsp_err, a_d_rsp_data, a_fault_cnt);
    end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_load();
    do_reset();
    d_req_valid = 1'b1;
    d_addr      = 32'h10;
    d_we        = 8'h00;
    #1;
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_addr !== 13'h10 || a_mem_we !== 8'h00) begin
      errors++;
      $display("FAIL load_issue got en=%0b addr=%0h we=%0h want en=1 addr=10 we=0",
               a_mem_en, a_mem_addr, a_mem_we);
    end
    @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    checks++;
    if (a_d_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL load_early got %0b want 0", a_d_rsp_valid);
    end
    @(negedge clk);
    mem_rdata = 64'hDEAD_BEEF;
    #1;
    checks++;
    if (a_d_rsp_valid !== 1'b1 || a_d_rsp_data !== 64'hDEAD_BEEF || a_d_rsp_err !== 1'b0 ||
        a_if_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_rsp got v=%0b data=%0h err=%0b iv=%0b want v=1 data=deadbeef err=0 iv=0",
               a_d_rsp_valid, a_d_rsp_data, a_d_rsp_err, a_if_rsp_valid);
    end
    @(negedge clk);
    mem_rdata = 64'h0;
    #1;
    checks++;
    if (a_d_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL load_pulse got %0b want 0", a_d_rsp_valid);
    end
  endtask

  task automatic test_starvation();
    logic [9:0]  want_f;
    logic [63:0] want_data;
    want_f = 10'b10_0001_0000;
    do_reset();
    if_addr = 32'h80;
    d_addr  = 32'h40;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      if_req_valid = (c < 10);
      d_req_valid  = (c < 10);
      mem_rdata    = 64'h1000 + 64'(c);
      want_data    = 64'h1000 + 64'(c);
      #1;
      if (c < 10) begin
        checks++;
        if (a_d_req_ready !== !want_f[c] || a_if_req_ready !== want_f[c] ||
            a_mem_addr !== (want_f[c] ? 13'h80 : 13'h40)) begin
          errors++;
          $display("FAIL starve_grant c=%0d got dr=%0b ir=%0b addr=%0h want fetch=%0b",
                   c, a_d_req_ready, a_if_req_ready, a_mem_addr, want_f[c]);
        end
      end
      if (c >= 2) begin
        checks++;
        if (a_d_rsp_valid !== !want_f[c-2] || a_if_rsp_valid !== want_f[c-2] ||
            (want_f[c-2] ? a_if_rsp_data : a_d_rsp_data) !== want_data) begin
          errors++;
          $display("FAIL starve_rsp c=%0d got dv=%0b iv=%0b dd=%0h id=%0h want fetch=%0b data=%0h",
                   c, a_d_rsp_valid, a_if_rsp_valid, a_d_rsp_data, a_if_rsp_data,
                   want_f[c-2], want_data);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_store_fault();
    do_reset();
    d_req_valid = 1'b1;
    d_addr      = 32'h2000;
    d_we        = 8'hFF;
    d_wdata     = 64'h1122_3344_5566_7788;
    #1;
    checks++;
    if (a_mem_en !== 1'b0 || a_mem_we !== 8'h00 || a_d_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL fault_issue got en=%0b we=%0h rdy=%0b want en=0 we=0 rdy=1",
               a_mem_en, a_mem_we, a_d_req_ready);
    end
    @(negedge clk);
    // In-range store right behind the fault.
    d_addr = 32'h0008;
    d_we   = 8'h0F;
    #1;
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_we !== 8'h0F || a_mem_addr !== 13'h8 ||
        a_mem_wdata !== 64'h1122_3344_5566_7788 || a_fault_cnt !== 16'd1) begin
      errors++;
      $display("FAIL store_issue got en=%0b we=%0h addr=%0h wd=%0h fc=%0d want 1 f 8 data fc=1",
               a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_fault_cnt);
    end
    @(negedge clk);
    idle_inputs();
    mem_rdata = 64'h1234;
    #1;
    checks++;
    if (a_d_rsp_valid !== 1'b1 || a_d_rsp_err !== 1'b1 || a_d_rsp_data !== 64'h0) begin
      errors++;
      $display("FAIL fault_rsp got v=%0b err=%0b data=%0h want v=1 err=1 data=0",
               a_d_rsp_valid, a_d_rsp_err, a_d_rsp_data);
    end
    @(negedge clk);
    mem_rdata = 64'h5678;
    #1;
    checks++;
    if (a_d_rsp_valid !== 1'b1 || a_d_rsp_err !== 1'b0 || a_d_rsp_data !== 64'h0 ||
        a_fault_cnt !== 16'd1) begin
      errors++;
      $display("FAIL store_rsp got v=%0b err=%0b data=%0h fc=%0d want v=1 err=0 data=0 fc=1",
               a_d_rsp_valid, a_d_rsp_err, a_d_rsp_data, a_fault_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic        want_v;
    logic [63:0] want_data;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      if (c > 0) @(negedge clk);
      if_req_valid = (c < 3);
      if_addr      = 32'(c * 8);
      mem_rdata    = 64'hA000_0000 + 64'(c);
      want_v       = (c >= 3) && (c <= 5);
      want_data    = want_v ? 64'hA000_0000 + 64'(c) : 64'h0;
      #1;
      if (c < 3) begin
        checks++;
        if (b_mem_en !== 1'b1 || b_mem_addr !== 13'(c * 8)) begin
          errors++;
          $display("FAIL b2b_issue c=%0d got en=%0b addr=%0h want en=1 addr=%0h",
                   c, b_mem_en, b_mem_addr, c * 8);
        end
      end
      checks++;
      if (b_if_rsp_valid !== want_v || b_if_rsp_data !== want_data || b_if_rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_rsp c=%0d got v=%0b data=%0h err=%0b want v=%0b data=%0h err=0",
                 c, b_if_rsp_valid, b_if_rsp_data, b_if_rsp_err, want_v, want_data);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req_valid = 1'b1;
    d_addr      = 32'h20;
    #1;
    checks++;
    if (a_mem_en !== 1'b1) begin
      errors++; $display("FAIL mid_issue got %0b want 1", a_mem_en);
    end
    for (int c = 1; c < 6; c++) begin
      @(negedge clk);
      rst         = (c <= 2);
      d_req_valid = (c <= 2);
      mem_rdata   = 64'h55;
      #1;
      checks++;
      if (a_d_rsp_valid !== 1'b0 || a_d_rsp_err !== 1'b0 || a_d_rsp_data !== 64'h0) begin
        errors++;
        $display("FAIL mid_rsp c=%0d got v=%0b err=%0b data=%0h want 0", c,
                 a_d_rsp_valid, a_d_rsp_err, a_d_rsp_data);
      end
      if (c <= 2) begin
        checks++;
        if (a_d_req_ready !== 1'b0 || a_if_req_ready !== 1'b0 || a_mem_en !== 1'b0 ||
            a_mem_we !== 8'h0) begin
          errors++;
          $display("FAIL mid_rst_out c=%0d got dr=%0b ir=%0b en=%0b we=%0h want 0", c,
                   a_d_req_ready, a_if_req_ready, a_mem_en, a_mem_we);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_fault_sat();
    logic [1:0] want_fc;
    do_reset();
    d_addr = 32'h4000;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      d_req_valid = (k < 5);
      want_fc     = (k > 3) ? 2'd3 : 2'(k);
      #1;
      checks++;
      if (c_fault_cnt !== want_fc) begin
        errors++; $display("FAIL fault_sat k=%0d got %0d want %0d", k, c_fault_cnt, want_fc);
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_load();
    test_starvation();
    test_store_fault();
    test_back_to_back();
    test_reset_mid();
    test_fault_sat();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_mem_bridge.md
CORE_MEM_BRIDGE -- requirements
Module: core_mem_bridge

Interface
REQ-001 Parameter LOAD_LATENCY, default 1, is the memory read latency in cycles; the legal range is 1..4.
REQ-002 Parameter ADDR_W, default 32, is the width of core-side addresses.
REQ-003 Parameter ACTUAL_ADDR_W, default 13, is the width of the physical memory address.
REQ-004 Parameter DATA_W, default 64, is the data width; WE_W, default 8, is the byte-enable width and SHALL equal DATA_W/8.
REQ-005 Parameter STARVE_LIMIT, default 4, is the number of consecutive data-port grants with fetch pending before fetch is forced.
REQ-006 Parameter FAULT_CNT_W, default 16, is the width of the fault counter.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high.
REQ-008 clk  in  1  is the single clock; all state updates on the rising edge.
REQ-009 rst  in  1  is the synchronous active-high reset.
REQ-010 if_req_valid in 1, if_req_ready out 1, if_addr in ADDR_W form the instruction-fetch request; fetches are read-only.
REQ-011 if_rsp_valid out 1, if_rsp_data out DATA_W, if_rsp_err out 1 form the fetch response.
REQ-012 d_req_valid in 1, d_req_ready out 1, d_addr in ADDR_W, d_we in WE_W, d_wdata in DATA_W form the data request; any d_we bit set means store, otherwise load.
REQ-013 d_rsp_valid out 1, d_rsp_data out DATA_W, d_rsp_err out 1 form the data response.
REQ-014 mem_en out 1, mem_addr out ACTUAL_ADDR_W, mem_we out WE_W, mem_wdata out DATA_W, mem_rdata in DATA_W form the single shared memory port.
REQ-015 fault_cnt out FAULT_CNT_W counts faulting requests.

Function
REQ-016 A request issues when valid&ready on its port; at most one request SHALL issue per cycle.
REQ-017 Arbitration: the data port SHALL win by default, so if_req_ready = !d_req_valid | force_if and d_req_ready = !force_if.
REQ-018 Starvation counter: it SHALL increment on each data issue while if_req_valid=1, and clear on any fetch issue or when if_req_valid=0.
REQ-019 Starvation force: force_if=1 when the counter reaches STARVE_LIMIT and if_req_valid=1; the forced fetch SHALL issue that cycle and the counter SHALL return to 0.
REQ-020 Address fault: a request is in-range iff addr[ADDR_W-1:ACTUAL_ADDR_W]==0; otherwise it faults.
REQ-021 In-range issue: mem_en=1, mem_addr=addr[ACTUAL_ADDR_W-1:0], mem_we=d_we (0 for fetch), and mem_wdata=d_wdata, all combinational in the issue cycle.
REQ-022 Faulting issue: mem_en=0 and mem_we=0, so no memory access and no store occurs.
REQ-023 When no request issues, mem_en=0 and mem_we=0, and mem_addr/mem_wdata are don't-care.
REQ-024 Response pipeline: LOAD_LATENCY stages, each holding {valid, port, store, err}.
REQ-025 Response timing: the response for a request issued in cycle t SHALL appear exactly in cycle t+LOAD_LATENCY on its port's rsp signals as a single-cycle pulse.
REQ-026 Load or fetch in-range response: rsp_data=mem_rdata sampled in the response cycle, err=0.
REQ-027 Store response: d_rsp_valid=1, d_rsp_data=0, d_rsp_err=0.
REQ-028 Fault response: rsp_valid=1, rsp_data=0, err=1.
REQ-029 Responses SHALL preserve issue order; full throughput is one request per cycle with no bubbles; there is no response backpressure.
REQ-030 Fault counter: fault_cnt SHALL increment by 1 per issued faulting request and saturate at all-ones.

Reset
REQ-031 While rst=1: if_req_ready=0, d_req_ready=0, mem_en=0, mem_we=0.
REQ-032 While rst=1: all rsp_valid=0, rsp_err=0, rsp_data=0.
REQ-033 While rst=1: the pipeline is cleared, the starvation counter is 0, and fault_cnt=0.
REQ-034 Reset mid-operation: in-flight responses SHALL be dropped and never emitted after rst deasserts.
REQ-035 The first issue is possible in the first cycle with rst=0.

Verification
REQ-036 LOAD_LATENCY=2, data load to d_addr=0x10 with mem_rdata=0xDEADBEEF at t+2 -> mem_en=1 and mem_addr=0x10 at t; d_rsp_valid=1 with data 0xDEADBEEF at t+2 only.
REQ-037 Both ports valid for 10 cycles with STARVE_LIMIT=4 -> grant sequence D,D,D,D,F,D,D,D,D,F; responses return in that order.
REQ-038 Store d_addr=0x2000 (bit 13 set) with d_we=0xFF -> mem_en=0 and mem_we=0; d_rsp_err=1 with data 0 at t+LOAD_LATENCY; fault_cnt=1.
REQ-039 LOAD_LATENCY=3 with back-to-back fetches at addrs 0,8,16 -> three consecutive if_rsp_valid pulses at t+3..t+5 carrying the corresponding mem_rdata.
REQ-040 rst asserted one cycle after a load issues with LOAD_LATENCY=2 -> no d_rsp_valid ever appears; all outputs hold reset values during rst.
REQ-041 FAULT_CNT_W=2 with five faulting requests -> fault_cnt goes 1,2,3,3,3.
